// File: rtl/seg_scan_ctrl.sv
// Scan controller for NDIG common-anode 7-segment digits sharing one external
// hex decoder. Holds a double-buffered display value, steps through the digits
// with a blank gap before each one, and applies mask and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 50000,
  parameter int GAP   = 500
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ld_valid,
  output logic                o_ld_ready,
  input  logic [4*NDIG-1:0]   i_ld_data,
  input  logic [NDIG-1:0]     i_ld_blank,
  input  logic                i_lzb,
  output logic [3:0]          o_dec_nib,
  input  logic [6:0]          i_dec_seg,
  output logic [6:0]          o_seg_n,
  output logic [NDIG-1:0]     o_an_n,
  output logic                o_frame_tick
);

  localparam int MAXLEN = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam int IW     = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic {
    S_GAP = 1'b0,
    S_ON  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic                w_last;
  logic                w_enter_on;
  logic                w_enter_gap;
  logic                w_boundary;

  logic [4*NDIG-1:0]   r_act_data;
  logic [NDIG-1:0]     r_act_mask;
  logic [4*NDIG-1:0]   r_pend_data;
  logic [NDIG-1:0]     r_pend_mask;
  logic                r_pend_full;
  logic                r_frame_tick;

  logic [6:0]          r_seg_n;
  logic [NDIG-1:0]     r_an_n;
  logic [NDIG-1:0]     w_an_on;
  logic                w_mask_bit;
  logic                w_upper_zero;
  logic                w_blank;

  // State, dwell counter and digit index registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_GAP;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic: count to the state length, then toggle; advance the digit when a lit period ends.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_last      = 1'b0;
    case (r_state)
      S_GAP: begin
        w_last = (r_cnt == GAP_LAST);
        if (w_last) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = '0;
        end
      end
      S_ON: begin
        w_last = (r_cnt == DWELL_LAST);
        if (w_last) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_enter_on  = (r_state == S_GAP) && w_last;
  assign w_enter_gap = (r_state == S_ON) && w_last;
  assign w_boundary  = w_enter_gap && (r_idx == IDX_LAST);

  // Select the active nibble and anode for the current index, and find whether all digits from idx upward are zero.
  always_comb begin
    o_dec_nib    = 4'h0;
    w_an_on      = '1;
    w_mask_bit   = 1'b0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == IW'(i)) begin
        o_dec_nib  = r_act_data[4*i +: 4];
        w_an_on[i] = 1'b0;
        w_mask_bit = r_act_mask[i];
      end
      if ((IW'(i) >= r_idx) && (r_act_data[4*i +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign w_blank = w_mask_bit || (i_lzb && (r_idx != '0) && w_upper_zero);

  // Segment and anode pins: load decoded digit on entering the lit state, go dark on entering the gap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_an_n  <= '1;
      r_seg_n <= 7'h7F;
    end else if (w_enter_on) begin
      r_an_n  <= w_an_on;
      r_seg_n <= w_blank ? 7'h7F : i_dec_seg;
    end else if (w_enter_gap) begin
      r_an_n  <= '1;
      r_seg_n <= 7'h7F;
    end
  end

  // Double buffer: accept a load into pending, move pending to active only at the frame boundary.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_act_data   <= '0;
      r_act_mask   <= '0;
      r_pend_data  <= '0;
      r_pend_mask  <= '0;
      r_pend_full  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary && r_pend_full;
      if (w_boundary && r_pend_full) begin
        r_act_data  <= r_pend_data;
        r_act_mask  <= r_pend_mask;
        r_pend_full <= 1'b0;
      end else if (i_ld_valid && !r_pend_full) begin
        r_pend_data <= i_ld_data;
        r_pend_mask <= i_ld_blank;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign o_ld_ready   = !r_pend_full;
  assign o_frame_tick = r_frame_tick;
  assign o_seg_n      = r_seg_n;
  assign o_an_n       = r_an_n;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, DWELL=4, GAP=2 (24-cycle frame).
// A table of display values is loaded one per frame; hand-written sequences
// cover live lzb changes, back-to-back loads and reset in the middle of a frame.
module tb_seg_scan_ctrl;

  localparam int FRAME = 24;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      blank;
    logic            lzb;
    logic [3:0][6:0] segs;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        ldValid;
  logic        ldReady;
  logic [15:0] ldData;
  logic [3:0]  ldBlank;
  logic        lzb;
  logic [3:0]  decNib;
  logic [6:0]  decSeg;
  logic [6:0]  segN;
  logic [3:0]  anN;
  logic        frameTick;

  int              phase;
  int              vectors;
  int              fails;
  int              tickCount;
  logic [3:0][6:0] curSegs;
  logic [15:0]     curData;
  logic            curLzb;
  vec_t            vecs[6];

  seg_scan_ctrl #(
    .NDIG  (4),
    .DWELL (4),
    .GAP   (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_ld_valid   (ldValid),
    .o_ld_ready   (ldReady),
    .i_ld_data    (ldData),
    .i_ld_blank   (ldBlank),
    .i_lzb        (lzb),
    .o_dec_nib    (decNib),
    .i_dec_seg    (decSeg),
    .o_seg_n      (segN),
    .o_an_n       (anN),
    .o_frame_tick (frameTick)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared decoder: hex to active-low gfedcba.
  function automatic logic [6:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign decSeg = hexSeg(decNib);

  function automatic vec_t mkVec(input logic [15:0] data, input logic [3:0] blank,
                                 input logic lz, input logic [3:0][6:0] segs);
    vec_t v;
    v.data  = data;
    v.blank = blank;
    v.lzb   = lz;
    v.segs  = segs;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s phase=%0d got=%h expected=%h", name, phase % FRAME, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data,
                               input logic [3:0] blank, input logic lz);
    ldValid = valid;
    ldData  = data;
    ldBlank = blank;
    lzb     = lz;
  endtask

  // Advance n cycles, checking anodes, segments, decoder nibble and frame tick at each.
  task automatic runCycles(input int n, input logic [3:0][6:0] segs,
                           input logic [15:0] data, input logic tickAt);
    int m;
    int d;
    int q;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic [3:0] expNib;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      phase++;
      m = phase % FRAME;
      d = m / 6;
      q = m % 6;
      expAn  = (q < 2) ? 4'hF : ~(4'b0001 << d);
      expSeg = (q < 2) ? 7'h7F : segs[d];
      expNib = data[4*d +: 4];
      checkOutput("anN", 16'(anN), 16'(expAn));
      checkOutput("segN", 16'(segN), 16'(expSeg));
      checkOutput("decNib", 16'(decNib), 16'(expNib));
      if (frameTick === 1'b1) tickCount++;
      checkOutput("frameTick", 16'(frameTick), 16'((m == 0) ? tickAt : 1'b0));
    end
  endtask

  // From phase 23: load v mid-frame, finish the old frame, then commit at the boundary (ends at phase 0).
  task automatic loadVector(input vec_t v);
    runCycles(9, curSegs, curData, 1'b0);
    applyStimulus(1'b1, v.data, v.blank, curLzb);
    runCycles(1, curSegs, curData, 1'b0);
    applyStimulus(1'b0, v.data, v.blank, curLzb);
    checkOutput("ldReadyLow", 16'(ldReady), 16'd0);
    runCycles(14, curSegs, curData, 1'b0);
    checkOutput("ldReadyHeld", 16'(ldReady), 16'd0);
    applyStimulus(1'b0, v.data, v.blank, v.lzb);
    runCycles(1, v.segs, v.data, 1'b1);
    checkOutput("ldReadyBack", 16'(ldReady), 16'd1);
    curSegs = v.segs;
    curData = v.data;
    curLzb  = v.lzb;
  endtask

  task automatic checkResetState();
    checkOutput("rstAnN", 16'(anN), 16'h000F);
    checkOutput("rstSegN", 16'(segN), 16'h007F);
    checkOutput("rstReady", 16'(ldReady), 16'd1);
    checkOutput("rstTick", 16'(frameTick), 16'd0);
    checkOutput("rstNib", 16'(decNib), 16'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout phase=%0d got=running expected=finished", phase % FRAME);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int ticksBefore;
    vec_t vb;
    vectors   = 0;
    fails     = 0;
    tickCount = 0;
    phase     = 0;
    curSegs   = {7'h40, 7'h40, 7'h40, 7'h40};
    curData   = 16'h0000;
    curLzb    = 1'b0;

    vecs[0] = mkVec(16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19});
    vecs[1] = mkVec(16'h0008, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h00});
    vecs[2] = mkVec(16'h5678, 4'b0100, 1'b0, {7'h12, 7'h7F, 7'h78, 7'h00});
    vecs[3] = mkVec(16'h00A0, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h40});
    vecs[4] = mkVec(16'h0000, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    vecs[5] = mkVec(16'hF00F, 4'b0000, 1'b1, {7'h0E, 7'h40, 7'h40, 7'h0E});

    // Reset, then two idle frames of 0000.
    rstN = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    phase = 0;
    checkResetState();
    rstN = 1'b1;
    runCycles(23, curSegs, curData, 1'b0);
    runCycles(24, curSegs, curData, 1'b0);

    // Table of display values, one committed per frame.
    for (int i = 0; i < 6; i++) begin
      loadVector(vecs[i]);
      runCycles(23, curSegs, curData, 1'b0);
    end

    // Live lzb: 0008 with lzb=1, then drop lzb before digit 1 lights.
    vb = mkVec(16'h0008, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h00});
    loadVector(vb);
    runCycles(7, vb.segs, vb.data, 1'b0);
    applyStimulus(1'b0, 16'h0008, 4'b0000, 1'b0);
    curLzb  = 1'b0;
    curSegs = {7'h40, 7'h40, 7'h40, 7'h00};
    runCycles(16, curSegs, curData, 1'b0);

    // Back-to-back loads: A accepted, B held until A commits.
    ticksBefore = tickCount;
    runCycles(9, curSegs, curData, 1'b0);
    applyStimulus(1'b1, 16'h9ABC, 4'b0000, 1'b0);
    runCycles(1, curSegs, curData, 1'b0);
    checkOutput("bbReadyA", 16'(ldReady), 16'd0);
    applyStimulus(1'b1, 16'hDEF0, 4'b0000, 1'b0);
    runCycles(14, curSegs, curData, 1'b0);
    checkOutput("bbReadyHold", 16'(ldReady), 16'd0);
    curSegs = {7'h10, 7'h08, 7'h03, 7'h46};
    curData = 16'h9ABC;
    runCycles(1, curSegs, curData, 1'b1);
    checkOutput("bbReadyOpen", 16'(ldReady), 16'd1);
    runCycles(1, curSegs, curData, 1'b0);
    checkOutput("bbReadyB", 16'(ldReady), 16'd0);
    applyStimulus(1'b0, 16'hDEF0, 4'b0000, 1'b0);
    runCycles(22, curSegs, curData, 1'b0);
    curSegs = {7'h21, 7'h06, 7'h0E, 7'h40};
    curData = 16'hDEF0;
    runCycles(1, curSegs, curData, 1'b1);
    runCycles(23, curSegs, curData, 1'b0);
    runCycles(1, curSegs, curData, 1'b0);
    checkOutput("bbTickPulses", 16'(tickCount - ticksBefore), 16'd2);
    runCycles(23, curSegs, curData, 1'b0);

    // Reset while digit 2 is lit and a value is pending.
    runCycles(13, curSegs, curData, 1'b0);
    applyStimulus(1'b1, 16'h1111, 4'b0000, 1'b0);
    runCycles(1, curSegs, curData, 1'b0);
    applyStimulus(1'b0, 16'h1111, 4'b0000, 1'b0);
    checkOutput("midRstPending", 16'(ldReady), 16'd0);
    runCycles(1, curSegs, curData, 1'b0);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    phase = 0;
    checkResetState();
    rstN = 1'b1;
    curSegs = {7'h40, 7'h40, 7'h40, 7'h40};
    curData = 16'h0000;
    runCycles(23, curSegs, curData, 1'b0);
    runCycles(24, curSegs, curData, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across NDIG common-anode digits.
- Owns a double-buffered display value, the digit-scan sequencing, the inter-digit ghosting gap, and leading-zero blanking.
- Sits between the value producer (motion-count and status logic) and the board's segment and anode pins.
- The decoder stays external: this block drives its nibble input and samples its 7-bit active-low output.

Parameters:
- NDIG, 4, number of digits scanned (2..8).
- DWELL, 50000, clock cycles each digit is lit (>=1).
- GAP, 500, clock cycles all anodes are off before each digit (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- ld_valid  in  1  producer has a new display value
- ld_ready  out  1  pending buffer empty, load accepted
- ld_data  in  4*NDIG  hex nibbles; digit i = ld_data[4i+3:4i], digit 0 = least significant
- ld_blank  in  NDIG  per-digit force-blank mask, loaded with ld_data
- lzb  in  1  leading-zero blanking enable (live, not buffered)
- dec_nib  out  4  nibble to shared decoder, combinational from active value and scan index
- dec_seg  in  7  decoder output, active-low segments
- seg_n  out  7  registered segment pins, active-low
- an_n  out  NDIG  registered anode enables, active-low one-hot
- frame_tick  out  1  one-cycle pulse when a pending value is committed

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-frame):
  - state=S_GAP, idx=0, cnt=0.
  - an_n all ones, seg_n=7'h7F.
  - active data=0, active mask=0, pending empty.
  - ld_ready=1, frame_tick=0.
- FSM has two states, S_GAP and S_ON.
  - S_GAP: held GAP cycles; an_n all ones; seg_n=7'h7F.
  - S_ON: held DWELL cycles; an_n[idx]=0, all other bits 1.
  - cnt counts 0..(len-1) within a state; at len-1, cnt resets to 0 and the state toggles.
  - Leaving S_ON: idx increments, wrapping NDIG-1 -> 0.
- Output timing:
  - an_n and seg_n are registered and load on the edge that enters S_ON.
  - seg_n = dec_seg sampled at that edge, or 7'h7F if the digit is blanked. It holds through S_ON.
  - An edge entering S_GAP loads an_n all ones and seg_n=7'h7F.
- Frame period = NDIG*(GAP+DWELL) cycles.
- dec_nib = active nibble[idx] at all times; idx is stable throughout S_GAP, so decoder settling is covered.
- A digit is blanked if any of these holds:
  - active mask[idx]=1;
  - lzb=1, idx>0, and every active nibble from index NDIG-1 down to idx is 0.
  - Digit 0 is never blanked by lzb.
- Load handshake:
  - A transfer occurs when ld_valid & ld_ready at a clk edge; ld_data and ld_blank are captured into pending.
  - ld_ready deasserts on the next cycle and stays 0 while pending is full.
- Commit happens only at the frame boundary: the edge leaving S_ON with idx=NDIG-1.
  - If pending is full, pending moves to active, pending clears, ld_ready=1 on the following cycle, and frame_tick=1 for that one cycle.
  - If pending is empty, there is no commit and frame_tick=0.
  - A transfer and a commit never coincide, because ld_ready=0 whenever pending is full.
  - A transfer on the boundary edge itself fills pending; it commits at the next boundary.
- Multiple ld_valid pulses while ld_ready=0 are ignored; the producer must hold the value.
- Display never tears: a value changes only between frames.
- Widths: cnt is $clog2(max(DWELL,GAP)+1) bits; idx is $clog2(NDIG) bits, minimum 1. No truncation of GAP or DWELL.

Test Plan:
- Bench setup (all scenarios): NDIG=4, DWELL=4, GAP=2, and a behavioural hex decoder with 0 -> 7'h40 and 8 -> 7'h00.
- Reset then idle: an_n=4'hF for 2 cycles, then 4'hE for 4 cycles with seg_n=7'h40, then the same pattern for 4'hD, 4'hB, 4'h7. The frame repeats every 24 cycles; frame_tick stays 0.
- Load 16'h1234 mid-frame:
  - ld_ready falls the next cycle.
  - The current frame still shows 0000.
  - At the boundary frame_tick pulses once and ld_ready returns to 1.
  - The next frame shows seg_n 7'h19, 7'h30, 7'h24, 7'h79 on digits 0..3 (4,3,2,1).
- Load 16'h0008 with lzb=1: digits 3,2,1 lit with seg_n=7'h7F; digit 0 shows 7'h00. Dropping lzb to 0 shows 7'h40 on digits 1..3 within the same frame.
- Two back-to-back ld_valid values, A then B: A is accepted, B is held off until ld_ready=1. A displays one full frame, then B commits at the next boundary. The commits produce exactly two frame_tick pulses.
- Load with ld_blank=4'b0100: digit 2 shows seg_n=7'h7F with an_n=4'hB. The other digits decode normally.
- Assert rst_n=0 for one edge while in S_ON of digit 2 with pending full: the next cycle shows an_n=4'hF, seg_n=7'h7F, ld_ready=1, and the display returns to 0000 on digit 0 after 2 gap cycles.
